// File: rtl/tle_pkg.sv
// -----------------------------------------------------------------------------
// Module     : tle_pkg
// Description: Shared types and defaults for the tile sequencer slice.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package tle_pkg;

  localparam int c_idx_w_dflt = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Result tag carried through the tag FIFO alongside each in-flight op
  typedef struct packed {
    logic [c_idx_w_dflt-1:0] m;
    logic [c_idx_w_dflt-1:0] n;
    logic                    last;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/tle_tag_fifo.sv
// -----------------------------------------------------------------------------
// Module     : tle_tag_fifo
// Description: Synchronous tag FIFO; push and pop together while full is legal.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tle_tag_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 17,
  parameter int CNT_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign w_do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign w_do_push = push_i && (!w_full || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/tle_tile_sequencer.sv
// -----------------------------------------------------------------------------
// Module     : tle_tile_sequencer
// Description: Issues (m,n,k) tile ops k-outermost, tracks in-flight tags.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tle_tile_sequencer
  import tle_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int IDX_W     = c_idx_w_dflt
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [IDX_W-1:0] m_tiles_i,
  input  logic [IDX_W-1:0] n_tiles_i,
  input  logic [IDX_W-1:0] k_tiles_i,
  input  logic             halved_precision_i,
  input  logic [3:0]       bit_size_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic             issue_valid_o,
  input  logic             issue_ready_i,
  output logic [IDX_W-1:0] issue_m_o,
  output logic [IDX_W-1:0] issue_n_o,
  output logic [IDX_W-1:0] issue_k_o,
  output logic             issue_first_o,
  output logic             issue_last_o,
  output logic             halved_precision_o,
  output logic [3:0]       bit_size_o,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  output logic [IDX_W-1:0] res_m_o,
  output logic [IDX_W-1:0] res_n_o,
  output logic             res_last_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i
);

  localparam int c_cnt_w = $clog2(MAX_OUTST + 1);
  localparam int c_tag_w = 2 * IDX_W + 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_m;
  logic [IDX_W-1:0]   r_n;
  logic [IDX_W-1:0]   r_k;
  logic [IDX_W-1:0]   r_m_tiles;
  logic [IDX_W-1:0]   r_n_tiles;
  logic [IDX_W-1:0]   r_k_tiles;
  logic               r_halved;
  logic [3:0]         r_bit_size;
  logic               r_cfg_err;
  logic [c_cnt_w-1:0] w_outst;
  logic               w_fifo_empty;
  logic [c_tag_w-1:0] w_head;
  logic [2*IDX_W-1:0] w_mn;
  logic               w_cfg_bad;
  logic               w_n_wrap;
  logic               w_m_wrap;
  logic               w_k_wrap;
  logic               w_room;
  logic               w_dep_ok;
  logic               w_issue_hs;
  logic               w_res_hs;
  logic               w_drained;

  assign w_cfg_bad = (m_tiles_i == '0) || (n_tiles_i == '0) || (k_tiles_i == '0);
  assign w_mn      = {{IDX_W{1'b0}}, r_m_tiles} * {{IDX_W{1'b0}}, r_n_tiles};
  assign w_n_wrap  = (r_n == r_n_tiles - IDX_W'(1));
  assign w_m_wrap  = (r_m == r_m_tiles - IDX_W'(1));
  assign w_k_wrap  = (r_k == r_k_tiles - IDX_W'(1));
  assign w_room    = (w_outst < c_cnt_w'(MAX_OUTST));
  // With fewer than m*n ops in flight, (m,n,k-1) has already returned
  assign w_dep_ok  = (r_k == '0) || ((2 * IDX_W)'(w_outst) < w_mn);

  assign issue_valid_o = (r_state == ST_RUN) && !rst_i && w_room && w_dep_ok;
  assign w_issue_hs    = issue_valid_o && issue_ready_i;
  assign issue_m_o     = r_m;
  assign issue_n_o     = r_n;
  assign issue_k_o     = r_k;
  assign issue_first_o = (r_k == '0);
  assign issue_last_o  = w_k_wrap;

  assign res_ready_o = wb_ready_i && !w_fifo_empty && !rst_i;
  assign wb_valid_o  = res_valid_i && !w_fifo_empty && !rst_i;
  assign w_res_hs    = res_valid_i && res_ready_o;
  assign res_m_o     = w_head[c_tag_w-1 -: IDX_W];
  assign res_n_o     = w_head[IDX_W -: IDX_W];
  assign res_last_o  = w_head[0];

  assign halved_precision_o = r_halved;
  assign bit_size_o         = r_bit_size;

  // Looks at the outstanding count after this cycle's pop so done follows the last result directly
  assign w_drained = (w_outst == '0) || ((w_outst == c_cnt_w'(1)) && w_res_hs);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    cfg_err_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = w_cfg_bad ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (w_issue_hs && w_n_wrap && w_m_wrap && w_k_wrap) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (w_drained) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_o      = 1'b1;
        cfg_err_o   = r_cfg_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (rst_i) begin
      busy_o    = 1'b0;
      done_o    = 1'b0;
      cfg_err_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m        <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_m_tiles  <= '0;
      r_n_tiles  <= '0;
      r_k_tiles  <= '0;
      r_halved   <= 1'b0;
      r_bit_size <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start_i) begin
        r_cfg_err <= w_cfg_bad;
        r_m       <= '0;
        r_n       <= '0;
        r_k       <= '0;
        if (!w_cfg_bad) begin
          r_m_tiles  <= m_tiles_i;
          r_n_tiles  <= n_tiles_i;
          r_k_tiles  <= k_tiles_i;
          r_halved   <= halved_precision_i;
          r_bit_size <= bit_size_i;
        end
      end
      if (w_issue_hs) begin
        if (!w_n_wrap) begin
          r_n <= r_n + IDX_W'(1);
        end else begin
          r_n <= '0;
          if (!w_m_wrap) begin
            r_m <= r_m + IDX_W'(1);
          end else begin
            r_m <= '0;
            r_k <= w_k_wrap ? '0 : r_k + IDX_W'(1);
          end
        end
      end
    end
  end

  tle_tag_fifo #(
    .DEPTH  (MAX_OUTST),
    .DATA_W (c_tag_w),
    .CNT_W  (c_cnt_w)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_issue_hs),
    .push_data_i ({r_m, r_n, w_k_wrap}),
    .pop_i       (w_res_hs),
    .head_o      (w_head),
    .empty_o     (w_fifo_empty),
    .count_o     (w_outst)
  );

endmodule

`default_nettype wire

// File: tb/tb_tle_tile_sequencer.sv
// -----------------------------------------------------------------------------
// Module     : tb_tle_tile_sequencer
// Description: Directed bench with a job-level model of issue order and results.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_tle_tile_sequencer;
  import tle_pkg::*;

  localparam int MAX_OUTST = 4;
  localparam int IDX_W     = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [IDX_W-1:0] m_tiles_i;
  logic [IDX_W-1:0] n_tiles_i;
  logic [IDX_W-1:0] k_tiles_i;
  logic             halved_precision_i;
  logic [3:0]       bit_size_i;
  logic             busy_o;
  logic             done_o;
  logic             cfg_err_o;
  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [IDX_W-1:0] issue_m_o;
  logic [IDX_W-1:0] issue_n_o;
  logic [IDX_W-1:0] issue_k_o;
  logic             issue_first_o;
  logic             issue_last_o;
  logic             halved_precision_o;
  logic [3:0]       bit_size_o;
  logic             res_valid_i;
  logic             res_ready_o;
  logic [IDX_W-1:0] res_m_o;
  logic [IDX_W-1:0] res_n_o;
  logic             res_last_o;
  logic             wb_valid_o;
  logic             wb_ready_i;

  always #5 clk = ~clk;

  tle_tile_sequencer #(.MAX_OUTST(MAX_OUTST), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .m_tiles_i(m_tiles_i), .n_tiles_i(n_tiles_i), .k_tiles_i(k_tiles_i),
    .halved_precision_i(halved_precision_i), .bit_size_i(bit_size_i),
    .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_m_o(issue_m_o), .issue_n_o(issue_n_o), .issue_k_o(issue_k_o),
    .issue_first_o(issue_first_o), .issue_last_o(issue_last_o),
    .halved_precision_o(halved_precision_o), .bit_size_o(bit_size_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_m_o(res_m_o), .res_n_o(res_n_o), .res_last_o(res_last_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i)
  );

  typedef struct { int m; int n; int k; bit first; bit last; } op_t;
  typedef struct { tag_t tag; int due; } fl_t;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc   = 0;

  // Model: expected op list for the job and in-flight results (engine FIFO)
  op_t ops[$];
  fl_t infl[$];
  bit  m_active = 0;
  bit  m_done_p = 0;
  bit  m_err    = 0;
  int  m_issued = 0;
  int  m_mn     = 0;
  bit  m_halved = 0;
  int  m_bits   = 0;
  int  lat      = 3;
  bit  ird      = 1;
  bit  wrdy     = 1;
  bit  force_rv = 0;

  // Observations of the DUT for hand-computed checks
  op_t obs[$];
  int  obs_icyc[$];
  int  obs_done_cyc, obs_err, obs_lres_cyc, obs_last_cnt, obs_iv_cnt, s_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cycle(input bit st, input bit rs);
    bit  g, e_iv, e_ne, ihs, rhs, acc;
    op_t o;
    op_t x;
    fl_t f;
    @(posedge clk);
    #2;
    start_i       = st;
    rst_i         = rs;
    issue_ready_i = ird;
    wb_ready_i    = wrdy;
    res_valid_i   = force_rv || (infl.size() > 0 && infl[0].due <= cyc);
    #1;
    g    = !rs;
    e_ne = infl.size() > 0;
    e_iv = 0;
    o    = '{0, 0, 0, 1'b0, 1'b0};
    if (m_active && m_issued < ops.size()) begin
      o    = ops[m_issued];
      e_iv = (infl.size() < MAX_OUTST) && (o.k == 0 || infl.size() < m_mn);
    end
    chk("busy", busy_o, g && m_active);
    chk("done", done_o, g && m_done_p);
    chk("cfg_err", cfg_err_o, g && m_done_p && m_err);
    chk("issue_valid", issue_valid_o, g && e_iv);
    if (g && e_iv) begin
      chk("issue_m", issue_m_o, o.m);
      chk("issue_n", issue_n_o, o.n);
      chk("issue_k", issue_k_o, o.k);
      chk("issue_first", issue_first_o, o.first);
      chk("issue_last", issue_last_o, o.last);
    end
    chk("wb_valid", wb_valid_o, g && e_ne && res_valid_i);
    chk("res_ready", res_ready_o, g && e_ne && wb_ready_i);
    if (g && e_ne) begin
      chk("res_m", res_m_o, infl[0].tag.m);
      chk("res_n", res_n_o, infl[0].tag.n);
      chk("res_last", res_last_o, infl[0].tag.last);
    end
    chk("halved", halved_precision_o, m_halved);
    chk("bit_size", bit_size_o, m_bits);

    if (issue_valid_o && issue_ready_i) begin
      x.m = int'(issue_m_o); x.n = int'(issue_n_o); x.k = int'(issue_k_o);
      x.first = issue_first_o; x.last = issue_last_o;
      obs.push_back(x);
      obs_icyc.push_back(cyc);
    end
    if (issue_valid_o) obs_iv_cnt++;
    if (res_valid_i && res_ready_o) begin
      obs_lres_cyc = cyc;
      if (res_last_o) obs_last_cnt++;
    end
    if (done_o) begin
      obs_done_cyc = cyc;
      obs_err      = int'(cfg_err_o);
    end

    ihs = g && e_iv && issue_ready_i;
    rhs = g && e_ne && res_valid_i && wb_ready_i;
    if (rs) begin
      m_active = 0; m_done_p = 0; m_err = 0; m_issued = 0;
      infl.delete(); ops.delete();
      m_halved = 0; m_bits = 0;
    end else begin
      acc      = st && !m_active && !m_done_p;
      m_done_p = 0;
      if (ihs) begin
        f.tag.m    = IDX_W'(o.m);
        f.tag.n    = IDX_W'(o.n);
        f.tag.last = o.last;
        f.due      = cyc + lat;
        infl.push_back(f);
        m_issued++;
      end
      if (rhs) begin
        void'(infl.pop_front());
        if (m_active && m_issued == ops.size() && infl.size() == 0) begin
          m_active = 0;
          m_done_p = 1;
        end
      end
      if (acc) begin
        if (m_tiles_i == 0 || n_tiles_i == 0 || k_tiles_i == 0) begin
          m_done_p = 1;
          m_err    = 1;
        end else begin
          m_active = 1;
          m_err    = 0;
          m_issued = 0;
          m_mn     = int'(m_tiles_i) * int'(n_tiles_i);
          m_halved = halved_precision_i;
          m_bits   = int'(bit_size_i);
          ops.delete();
          for (int k = 0; k < int'(k_tiles_i); k++)
            for (int m = 0; m < int'(m_tiles_i); m++)
              for (int n = 0; n < int'(n_tiles_i); n++)
                ops.push_back('{m, n, k, (k == 0), (k == int'(k_tiles_i) - 1)});
        end
      end
    end
    cyc++;
  endtask

  task automatic start_job(input int m, input int n, input int k, input int l,
                           input bit hp, input int bs);
    m_tiles_i = IDX_W'(m); n_tiles_i = IDX_W'(n); k_tiles_i = IDX_W'(k);
    halved_precision_i = hp; bit_size_i = 4'(bs); lat = l;
    obs.delete(); obs_icyc.delete();
    obs_iv_cnt = 0; obs_last_cnt = 0;
    obs_done_cyc = -1; obs_err = -1; obs_lres_cyc = -1;
    s_cyc = cyc;
    cycle(1, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_active || m_done_p) && n < budget) begin
      cycle(0, 0);
      n++;
    end
    if (m_active || m_done_p) begin
      n_vec++;
      n_err++;
      $display("FAIL job_timeout at cycle %0d: still busy after %0d cycles, expected idle", cyc, budget);
    end
  endtask

  function automatic int pack3(input op_t o);
    return (o.m << 16) | (o.n << 8) | o.k;
  endfunction

  initial begin
    rst_i = 1; start_i = 0; issue_ready_i = 1; wb_ready_i = 1; res_valid_i = 0;
    m_tiles_i = '0; n_tiles_i = '0; k_tiles_i = '0;
    halved_precision_i = 0; bit_size_i = '0;

    cycle(0, 1);
    cycle(0, 1);
    cycle(0, 0);
    chk("rst_issue_m", issue_m_o, 0);
    chk("rst_bit_size", bit_size_o, 0);

    // Single-tile job
    start_job(1, 1, 1, 3, 1, 5);
    wait_idle(50);
    chk("t1_issues", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("t1_first", obs[0].first, 1);
      chk("t1_last", obs[0].last, 1);
      chk("t1_issue_lat", obs_icyc[0] - s_cyc, 1);
    end
    chk("t1_done_lat", obs_done_cyc - obs_lres_cyc, 1);
    chk("t1_err", obs_err, 0);
    cycle(0, 0);

    // 2x2x3 job, window-limited by MAX_OUTST and the k dependency
    start_job(2, 2, 3, 5, 0, 7);
    wait_idle(300);
    chk("t2_issues", obs.size(), 12);
    if (obs.size() >= 12) begin
      chk("t2_op1", pack3(obs[1]), 32'h0000_0100);
      chk("t2_op2", pack3(obs[2]), 32'h0001_0000);
      chk("t2_op4", pack3(obs[4]), 32'h0000_0001);
      chk("t2_op11", pack3(obs[11]), 32'h0001_0102);
      chk("t2_k1_wait", obs_icyc[4] - obs_icyc[0], 6);
    end
    chk("t2_last_cnt", obs_last_cnt, 4);

    // 1x1x4: each op waits for the previous result
    start_job(1, 1, 4, 2, 1, 3);
    wait_idle(100);
    chk("t3_issues", obs.size(), 4);
    if (obs.size() >= 4) begin
      chk("t3_gap", obs_icyc[1] - obs_icyc[0], 3);
      chk("t3_op3", pack3(obs[3]), 32'h0000_0003);
    end

    // Issue stall of 10 cycles, ignored restart, and consumer backpressure
    start_job(2, 3, 1, 2, 0, 9);
    cycle(0, 0);
    cycle(0, 0);
    ird = 0;
    wrdy = 0;
    m_tiles_i = 8'd5;
    bit_size_i = 4'd1;
    cycle(1, 0);
    for (int i = 0; i < 9; i++) begin
      if (i == 2) wrdy = 1;
      cycle(0, 0);
    end
    chk("t4_bits_kept", bit_size_o, 9);
    ird = 1;
    wait_idle(100);
    chk("t4_issues", obs.size(), 6);
    if (obs.size() >= 6) begin
      chk("t4_op2", pack3(obs[2]), 32'h0000_0200);
      chk("t4_op3", pack3(obs[3]), 32'h0001_0000);
      chk("t4_op5", pack3(obs[5]), 32'h0001_0200);
    end

    // Rejected job
    start_job(3, 2, 0, 1, 1, 4);
    wait_idle(10);
    chk("t5_done_lat", obs_done_cyc - s_cyc, 1);
    chk("t5_err", obs_err, 1);
    chk("t5_no_issue", obs_iv_cnt, 0);
    chk("t5_cfg_kept", bit_size_o, 9);

    // Reset mid-job with two ops in flight, then a fresh job
    start_job(2, 2, 2, 8, 1, 6);
    cycle(0, 0);
    cycle(0, 0);
    chk("t6_inflight", obs.size(), 2);
    cycle(0, 1);
    force_rv = 1;
    cycle(0, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_res_ready", res_ready_o, 0);
    cycle(0, 0);
    cycle(0, 0);
    force_rv = 0;
    start_job(1, 1, 1, 3, 0, 2);
    wait_idle(50);
    chk("t7_issues", obs.size(), 1);
    chk("t7_done_lat", obs_done_cyc - obs_lres_cyc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tle_tile_sequencer.md
TLE_TILE_SEQUENCER -- requirements
Module: tle_tile_sequencer

Interface
REQ-001 Parameter MAX_OUTST, default 4: maximum tile operations in flight in the tile engine (sets tag FIFO depth).
REQ-002 Parameter IDX_W, default 8: width of tile indices and tile counts.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  job start pulse; accepted only in IDLE.
REQ-006 m_tiles_i, n_tiles_i, k_tiles_i  input  IDX_W each  job tile counts, latched on accepted start.
REQ-007 halved_precision_i  input  1; bit_size_i  input  4  precision config, latched on accepted start.
REQ-008 busy_o  output  1  high in RUN or DRAIN.
REQ-009 done_o  output  1  one-cycle job completion pulse; cfg_err_o  output  1  qualifies done_o for a rejected job.
REQ-010 issue_valid_o  output  1; issue_ready_i  input  1  tile-op handshake to the tile engine.
REQ-011 issue_m_o, issue_n_o, issue_k_o  output  IDX_W each  tile coordinates of the current op.
REQ-012 issue_first_o  output  1  (k==0, C from bias); issue_last_o  output  1  (k==k_tiles-1).
REQ-013 halved_precision_o  output  1; bit_size_o  output  4  latched config, constant for the whole job.
REQ-014 res_valid_i  input  1; res_ready_o  output  1  result handshake from the tile engine.
REQ-015 res_m_o, res_n_o  output  IDX_W each; res_last_o  output  1  tag of the result at the FIFO head.
REQ-016 wb_valid_o  output  1; wb_ready_i  input  1  result forwarding handshake toward the consumer.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE with start_i: any tile count of zero goes to DONE with cfg_err_o=1; otherwise config is latched and the FSM goes to RUN.
REQ-019 start_i in any state other than IDLE is ignored, with no effect on counters or config.
REQ-020 Issue order: n innermost, then m, then k outermost, all indices starting at 0.
REQ-021 issue_valid_o = RUN and outst<MAX_OUTST and (issue_k_o==0 or outst<m_tiles*n_tiles), where outst is the in-flight count.
REQ-022 The m_tiles*n_tiles product is computed 2*IDX_W wide. The check guarantees in-order return of (m,n,k-1) before (m,n,k) issues.
REQ-023 Issue handshake (issue_valid_o and issue_ready_i): indices advance and the tag {m,n,last} is pushed.
REQ-024 Coordinates and flags are stable while issue_valid_o is high and issue_ready_i is low.
REQ-025 The handshake on the final op (n,m,k all at max) moves RUN to DRAIN.
REQ-026 Result path is combinational: wb_valid_o = res_valid_i and fifo_not_empty; res_ready_o = wb_ready_i and fifo_not_empty.
REQ-027 Result handshake pops the FIFO. res_* outputs present the FIFO head tag.
REQ-028 outst increments on an issue handshake and decrements on a result handshake; both in the same cycle leaves it unchanged.
REQ-029 DRAIN moves to DONE when outst==0.
REQ-030 DONE asserts done_o for exactly one cycle, then goes to IDLE; cfg_err_o is 0 unless the job was rejected.
REQ-031 Latency: issue_valid_o can first be high the cycle after start is accepted.
REQ-032 Latency: done_o rises the cycle after the last result handshake.

Reset
REQ-033 rst_i high: state=IDLE, outst=0, FIFO empty, indices=0, latched config=0.
REQ-034 rst_i high: all outputs 0 (busy_o, done_o, cfg_err_o, issue_valid_o, res_ready_o, wb_valid_o).
REQ-035 Reset mid-job aborts immediately; results returning afterwards are not accepted (res_ready_o=0 while FIFO empty).

Structure
REQ-036 State enum, tag struct {m,n,last} and IDX_W default belong in shared package tle_pkg.
REQ-037 The tag FIFO is the sub-module tle_tag_fifo: depth MAX_OUTST, synchronous, simultaneous push/pop when full is legal.

Verification
REQ-038 m=n=k=1, engine latency 3 -> exactly one issue with first=last=1; done_o pulse one cycle after the result handshake.
REQ-039 m=2,n=2,k=3, latency 5, MAX_OUTST=4 -> 12 issues in order (0,0,0),(0,1,0),(1,0,0),(1,1,0),(0,0,1)..., each k>0 issue waits for outst<4, and res_last_o=1 on exactly the last 4 results.
REQ-040 m=1,n=1,k=4 -> issue k+1 only after the result of k returns (outst<1).
REQ-041 issue_ready_i low for 10 cycles mid-RUN -> issue outputs held stable; no index skip or duplication.
REQ-042 k_tiles=0 -> done_o=1 and cfg_err_o=1 one cycle after start; no issue_valid_o.
REQ-043 rst_i in RUN with 2 ops in flight -> IDLE next cycle; then a fresh start with m=n=k=1 completes normally.
